apb_slave_model: RTL and testbench
==================================

# apb_slave_model

Parametrised multi-slave APB completer model for the AHB-to-APB bridge test environment. It replaces the pass-through, random-read stub with clocked storage: each selected slave owns a small word memory and returns previously written data. Each transfer is completed with a configurable number of wait states via `pready`. Bad transfers are flagged on `pslverr`. It sits directly on the bridge's APB output bus and is the bridge's completer in all bridge-level benches.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: width of `paddr`.
- `DATA_WIDTH`, default 32: width of `pwdata` and `prdata`; must be 32 (byte-addressed words).
- `NUM_SLAVES`, default 3: width of `psel`; one memory per slave.
- `MEM_DEPTH`, default 16: words per slave; must be a power of 2, at least 2.
- `WAIT_CYCLES`, default 0: wait states per transfer, range 0–15.

Ports:
- `hclk` input 1: single clock; all state changes on the rising edge.
- `hresetn` input 1: asynchronous, active-low reset.
- `psel` input NUM_SLAVES: one-hot slave select.
- `penable` input 1: APB access phase.
- `pwrite` input 1: 1 = write, 0 = read.
- `paddr` input ADDR_WIDTH: byte address.
- `pwdata` input DATA_WIDTH: write data.
- `prdata` output DATA_WIDTH: read data.
- `pready` output 1: transfer completes this cycle.
- `pslverr` output 1: transfer error, valid only while `pready`=1.
- `xfer_cnt` output 16: number of completed transfers, wrapping.

## Operation
- Two-state FSM:
  - IDLE: setup phase detected when `psel`≠0 and `penable`=0. On that edge go to ACCESS, load `wcnt`←WAIT_CYCLES, and latch the following:
    - slave index (position of the set `psel` bit)
    - `paddr`, `pwrite`, `pwdata`
    - error flag
  - ACCESS: `pready`=(`wcnt`==0). While `wcnt`≠0 it decrements by 1 each edge.
  - Completion: on the edge with `pready`=1 and `penable`=1, return to IDLE.
- Error conditions, evaluated at setup from latched values:
  - `psel` not one-hot.
  - `paddr[1:0]`≠0.
  - `paddr` ≥ MEM_DEPTH*4. Address bits above the word index must be zero.
- Write: on the completion edge with no error, `mem[idx][paddr[clog2(MEM_DEPTH)+1:2]]`←latched `pwdata`. An erroring write changes nothing.
- Read: `prdata` = addressed word while `pready`=1 and the latched `pwrite`=0 and there is no error. `prdata`=0 at all other times; never X.
- `pslverr` = latched error flag while `pready`=1; otherwise 0.
- `xfer_cnt` increments on every completion edge, including erroring transfers, and wraps from 16'hFFFF to 0.
- Abort: in ACCESS, if `psel` goes to 0, return to IDLE with no write and no count increment.
- `penable`=1 while in IDLE with `psel`=0 is ignored.
- Reset, asynchronous, including mid-transfer:
  - FSM → IDLE, `wcnt`=0.
  - All memory words = 0, `xfer_cnt`=0.
  - `prdata`=0, `pready`=0, `pslverr`=0.

## Timing
- WAIT_CYCLES=0: setup in cycle T, `pready`=1 in T+1. Write data visible from T+2; a read launched in T+2 returns it in T+3.
- WAIT_CYCLES=N: `pready`=0 for cycles T+1 through T+N, and 1 in T+N+1.
- `pready`, `pslverr` and `prdata` are combinational from registered state and memory only; no input-to-output combinational path.
- Back-to-back transfers: the cycle after completion may be a new setup. There is no dead cycle beyond the APB minimum of 2 cycles per transfer.

## Structure
- Package `apb_model_pkg` holds:
  - FSM state encoding (IDLE, ACCESS)
  - `WCNT_W`=4
  - `XFER_CNT_W`=16
  - error-code localparams
- Sub-module `apb_slave_mem`: one per slave, instantiated with a generate loop. Each has a DEPTH×32 register array with asynchronous clear, a write-enable/address/data write port, and a combinational read port. The top module holds the FSM, the wait counter, the error decode and the output mux.

## Test plan
- Reset: hold `hresetn`=0 with random inputs → `prdata`=0, `pready`=0, `pslverr`=0, `xfer_cnt`=0. Read slave 0 at 0x0 after release → 0.
- WAIT_CYCLES=0: write 0xDEADBEEF to slave 1 at 0x04, then read slave 1 at 0x04 → `pready` is high in the second cycle of each transfer, the read returns 0xDEADBEEF, and `xfer_cnt`=2.
- WAIT_CYCLES=2: a read on slave 2 → `pready`=0 for exactly 2 access cycles, then 1 with the correct data. Also run back-to-back write then read with no idle cycle between them.
- Errors: `paddr`=0x40 with MEM_DEPTH=16, `paddr`=0x06, and `psel`=3'b011 → `pslverr`=1 with `pready`, `prdata`=0, memory unchanged, `xfer_cnt` still increments.
- Abort: with WAIT_CYCLES=3, drop `psel` during wait cycle 2 → FSM back to IDLE, no write, `xfer_cnt` unchanged.
- Reset mid-transfer: assert `hresetn` during ACCESS → all outputs 0 immediately, and memory reads back 0 after release.

Source files
------------

// File: rtl/apb_model_pkg.sv
// Shared types and constants for the APB completer model.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package apb_model_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam int WCNT_W     = 4;
    localparam int XFER_CNT_W = 16;

    // Error code is a small bit vector; any set bit makes the transfer fail.
    localparam int ERR_W     = 3;
    localparam int ERR_SEL   = 0;   // psel not one-hot
    localparam int ERR_ALIGN = 1;   // paddr not word aligned
    localparam int ERR_RANGE = 2;   // paddr beyond the slave's memory

endpackage

// File: rtl/apb_slave_mem.sv
// Per-slave word memory: async-clear register array, one write port, one read port.
// Latency: write lands on the clock edge; read is combinational from the array.
// Backpressure: none; the caller qualifies the write enable.
module apb_slave_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage: cleared on reset, written one word per qualified edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_model.sv
// Multi-slave APB completer with per-slave memory, fixed wait states and error flagging.
// Latency: pready rises WAIT_CYCLES+1 cycles after setup; writes visible the cycle after completion.
// Backpressure: holds pready low for WAIT_CYCLES access cycles; dropping psel aborts the transfer.
module apb_slave_model
    import apb_model_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SLAVES  = 3,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic [NUM_SLAVES-1:0] psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [15:0]           xfer_cnt
);

    localparam int AW    = $clog2(MEM_DEPTH);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    state_t                  state;
    state_t                  state_nxt;
    logic [WCNT_W-1:0]       wcnt;
    logic [IDX_W-1:0]        l_idx;
    logic [AW-1:0]           l_word;
    logic                    l_write;
    logic [DATA_WIDTH-1:0]   l_wdata;
    logic [ERR_W-1:0]        l_err;

    logic [IDX_W-1:0]        sel_idx;
    logic [ERR_W-1:0]        err_code;
    logic                    setup;
    logic                    done_wait;
    logic                    abort_xfer;
    logic                    complete;
    logic [DATA_WIDTH-1:0]   rd_all [NUM_SLAVES];
    logic [DATA_WIDTH-1:0]   rd_sel;

    // Setup-phase decode: lowest set psel bit picks the slave; error bits from the raw bus.
    always_comb begin
        sel_idx  = '0;
        err_code = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (psel[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        err_code[ERR_SEL]   = (psel == '0) || ((psel & (psel - NUM_SLAVES'(1))) != '0);
        err_code[ERR_ALIGN] = (paddr[1:0] != 2'b00);
        err_code[ERR_RANGE] = ((paddr >> (AW + 2)) != '0);
    end

    assign setup      = (state == ST_IDLE) && (psel != '0) && !penable;
    assign done_wait  = (state == ST_ACCESS) && (wcnt == '0);
    assign abort_xfer = (state == ST_ACCESS) && (psel == '0);
    assign complete   = done_wait && penable && !abort_xfer;

    // State register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and bus outputs; outputs depend only on registered state and memory.
    always_comb begin
        state_nxt = state;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        case (state)
            ST_IDLE:   if (setup) state_nxt = ST_ACCESS;
            ST_ACCESS: if (abort_xfer || complete) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (done_wait) begin
            pready  = 1'b1;
            pslverr = |l_err;
            if (!l_write && (l_err == '0)) begin
                prdata = rd_sel;
            end
        end
    end

    // Transfer context latched at setup; wait counter runs down during access.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wcnt    <= '0;
            l_idx   <= '0;
            l_word  <= '0;
            l_write <= 1'b0;
            l_wdata <= '0;
            l_err   <= '0;
        end else if (setup) begin
            wcnt    <= WCNT_W'(WAIT_CYCLES);
            l_idx   <= sel_idx;
            l_word  <= paddr[AW+1:2];
            l_write <= pwrite;
            l_wdata <= pwdata;
            l_err   <= err_code;
        end else if ((state == ST_ACCESS) && (wcnt != '0)) begin
            wcnt <= wcnt - WCNT_W'(1);
        end
    end

    // Completed-transfer counter, errors included, wrapping naturally.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            xfer_cnt <= '0;
        end else if (complete) begin
            xfer_cnt <= xfer_cnt + XFER_CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_mem
        apb_slave_mem #(
            .DEPTH (MEM_DEPTH),
            .WIDTH (DATA_WIDTH)
        ) u_mem (
            .clk   (hclk),
            .rst_n (hresetn),
            .we    (complete && l_write && (l_err == '0) && (l_idx == IDX_W'(g))),
            .waddr (l_word),
            .wdata (l_wdata),
            .raddr (l_word),
            .rdata (rd_all[g])
        );
    end

    // Read mux across slaves, keyed on the latched slave index.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (l_idx == IDX_W'(i)) begin
                rd_sel = rd_all[i];
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_model.sv
// Bench: three completers (0, 2 and 3 wait states) on a shared bus, one selected at a time.
// Latency: expected responses queued at issue, checked by a negedge monitor on pready.
// Backpressure: driver waits on pready with a bounded cycle budget.
module tb_apb_slave_model;

    logic        hclk;
    logic        hresetn;
    logic [2:0]  psel0, psel2, psel3;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata0, prdata2, prdata3;
    logic        pready0, pready2, pready3;
    logic        pslverr0, pslverr2, pslverr3;
    logic [15:0] xfer0, xfer2, xfer3;

    apb_slave_model #(.WAIT_CYCLES(0)) u_w0 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
        .pslverr(pslverr0), .xfer_cnt(xfer0));
    apb_slave_model #(.WAIT_CYCLES(2)) u_w2 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel2), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata2), .pready(pready2),
        .pslverr(pslverr2), .xfer_cnt(xfer2));
    apb_slave_model #(.WAIT_CYCLES(3)) u_w3 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel3), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3),
        .pslverr(pslverr3), .xfer_cnt(xfer3));

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          waits;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          act   = 0;
    logic [2:0]  m_psel;
    logic [31:0] m_prdata;
    logic        m_pready;
    logic        m_pslverr;
    logic [15:0] m_xfer;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Route the currently active completer onto the monitor view.
    always_comb begin
        case (act)
            0:       begin m_psel = psel0; m_prdata = prdata0; m_pready = pready0; m_pslverr = pslverr0; m_xfer = xfer0; end
            1:       begin m_psel = psel2; m_prdata = prdata2; m_pready = pready2; m_pslverr = pslverr2; m_xfer = xfer2; end
            default: begin m_psel = psel3; m_prdata = prdata3; m_pready = pready3; m_pslverr = pslverr3; m_xfer = xfer3; end
        endcase
    end

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp_v);
        end
    endfunction

    task automatic set_psel(input logic [2:0] s);
        psel0 = (act == 0) ? s : 3'b000;
        psel2 = (act == 1) ? s : 3'b000;
        psel3 = (act == 2) ? s : 3'b000;
    endtask

    // Full transfer; starts #1 after an edge, ends #1 after the completion edge.
    task automatic xfer(input logic [2:0] s, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                        input int ew);
        int n;
        exp_t e;
        e.data = ed; e.err = ee; e.waits = ew;
        q.push_back(e);
        set_psel(s);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        @(posedge hclk); #1;
        penable = 1'b1;
        n = 0;
        while (!m_pready && n < 20) begin
            @(posedge hclk); #1;
            n++;
        end
        if (!m_pready) begin
            total++;
            bad++;
            $display("FAIL pready_timeout: got no pready after %0d cycles, expected %0d waits", n, ew);
        end
        @(posedge hclk); #1;
    endtask

    task automatic idle();
        set_psel(3'b000);
        penable = 1'b0;
        @(posedge hclk); #1;
    endtask

    // Monitor: counts wait cycles in access and checks each completion against the queue.
    initial begin
        int wc;
        exp_t e;
        wc = 0;
        forever begin
            @(negedge hclk);
            if (hresetn && (m_psel != 3'b000) && penable) begin
                if (m_pready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pready: got pready with empty queue, expected none");
                    end else begin
                        e = q.pop_front();
                        chk("prdata", m_prdata, e.data);
                        chk("pslverr", {31'b0, m_pslverr}, {31'b0, e.err});
                        chk("wait_states", wc, e.waits);
                    end
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        hresetn = 1'b0;
        act     = 0;
        psel0 = 3'b0; psel2 = 3'b0; psel3 = 3'b0;
        penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;

        // Reset held with random bus activity: everything must read zero.
        for (int i = 0; i < 5; i++) begin
            @(posedge hclk); #1;
            psel0   = 3'($urandom_range(0, 7));
            psel2   = 3'($urandom_range(0, 7));
            psel3   = 3'($urandom_range(0, 7));
            penable = 1'($urandom_range(0, 1));
            pwrite  = 1'($urandom_range(0, 1));
            paddr   = $urandom;
            pwdata  = $urandom;
            @(negedge hclk);
            chk("rst_prdata0", prdata0, 32'h0);
            chk("rst_pready0", {31'b0, pready0}, 32'h0);
            chk("rst_pslverr0", {31'b0, pslverr0}, 32'h0);
            chk("rst_xfer3", {16'b0, xfer3}, 32'h0);
        end
        psel0 = 3'b0; psel2 = 3'b0; psel3 = 3'b0; penable = 1'b0;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;

        // Zero wait states: basic read, write, readback.
        act = 0;
        xfer(3'b001, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, 0);
        chk("xfer0_after_first", {16'b0, m_xfer}, 32'd1);
        xfer(3'b010, 1'b1, 32'h04, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        xfer(3'b010, 1'b0, 32'h04, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        idle();
        chk("xfer0_after_wr_rd", {16'b0, m_xfer}, 32'd3);

        // Error transfers, then confirm memory untouched.
        xfer(3'b001, 1'b1, 32'h40, 32'hBAD0BAD0, 32'h0, 1'b1, 0);
        xfer(3'b001, 1'b1, 32'h06, 32'h33333333, 32'h0, 1'b1, 0);
        xfer(3'b010, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 0);
        xfer(3'b011, 1'b1, 32'h04, 32'h11111111, 32'h0, 1'b1, 0);
        xfer(3'b010, 1'b1, 32'h1000_0004, 32'h22222222, 32'h0, 1'b1, 0);
        xfer(3'b001, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 0);
        xfer(3'b010, 1'b0, 32'h04, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        xfer(3'b001, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, 0);
        idle();
        chk("xfer0_after_errors", {16'b0, m_xfer}, 32'd11);

        // Two wait states, back-to-back write then read.
        act = 1;
        xfer(3'b100, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, 2);
        xfer(3'b100, 1'b1, 32'h08, 32'hCAFEF00D, 32'h0, 1'b0, 2);
        xfer(3'b100, 1'b0, 32'h08, 32'h0, 32'hCAFEF00D, 1'b0, 2);
        idle();
        chk("xfer2_count", {16'b0, m_xfer}, 32'd3);

        // Three wait states: write/read, then abort a write in wait cycle 2.
        act = 2;
        xfer(3'b010, 1'b1, 32'h0C, 32'hA5A5A5A5, 32'h0, 1'b0, 3);
        xfer(3'b010, 1'b0, 32'h0C, 32'h0, 32'hA5A5A5A5, 1'b0, 3);
        idle();
        set_psel(3'b001); pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h12345678; penable = 1'b0;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(posedge hclk); #1;
        set_psel(3'b000);
        @(posedge hclk); #1;
        penable = 1'b0;
        @(posedge hclk); #1;
        chk("abort_xfer_cnt", {16'b0, m_xfer}, 32'd2);
        chk("abort_pready", {31'b0, m_pready}, 32'h0);
        xfer(3'b001, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, 3);
        chk("xfer3_after_abort", {16'b0, m_xfer}, 32'd3);

        // Reset while pready is high on a read: outputs drop at once, memory clears.
        e.data = 32'hA5A5A5A5; e.err = 1'b0; e.waits = 3;
        q.push_back(e);
        set_psel(3'b010); pwrite = 1'b0; paddr = 32'h0C; penable = 1'b0;
        @(posedge hclk); #1;
        penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge hclk); #1;
        end
        @(negedge hclk); #1;
        hresetn = 1'b0;
        #1;
        chk("midrst_prdata", m_prdata, 32'h0);
        chk("midrst_pready", {31'b0, m_pready}, 32'h0);
        chk("midrst_pslverr", {31'b0, m_pslverr}, 32'h0);
        chk("midrst_xfer", {16'b0, m_xfer}, 32'h0);
        set_psel(3'b000); penable = 1'b0;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        xfer(3'b010, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, 3);
        idle();
        chk("xfer3_after_reset", {16'b0, m_xfer}, 32'd1);

        idle();
        idle();
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
